conv2_ch_sched: RTL and testbench

Channel scheduler for the conv2 stage. Accepts one input window at a time from the conv2 line buffer, steps the shared MAC array through every (output channel, input channel) pair, and accumulates the returned per-input-channel partial sums. For each output channel it adds the matching bias slice from the conv2 bias ROM, applies ReLU and saturation, and emits one result.

---
 rtl/conv2_ch_sched.sv | 212 +++++++++++++++++++++
 tb/tb_conv2_ch_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_ch_sched.sv
// conv2_ch_sched
// Channel scheduler for the conv2 stage. Takes one input window at a time,
// walks the shared MAC array through every (output channel, input channel)
// pair, accumulates the returned partial sums, then adds the per-channel bias,
// applies ReLU, shifts and saturates, and emits one result per output channel.
//
// Ports:
//   clk, reset_n          - rising-edge clock, asynchronous active-low reset
//   i_in_valid/o_in_ready - window handshake (ready only while idle)
//   i_bias                - flat bias bus, channel c at [c*B_BW +: B_BW], signed
//   o_mac_en/co/ci        - one K x K MAC request for the current (co, ci)
//   i_psum_valid/i_psum   - MAC result, arriving MAC_LAT cycles after o_mac_en
//   o_ot_valid/co/data    - registered result pulse, data is non-negative
//   o_done                - pulse coincident with the last channel's result

module conv2_ch_sched #(
    parameter int CO      = 3,
    parameter int CI      = 3,
    parameter int B_BW    = 16,
    parameter int ACC_BW  = 32,
    parameter int OUT_BW  = 16,
    parameter int MAC_LAT = 2,
    parameter int B_SHIFT = 0,
    parameter int O_SHIFT = 0,
    parameter int CO_W    = (CO > 1) ? $clog2(CO) : 1,
    parameter int CI_W    = (CI > 1) ? $clog2(CI) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [CO*B_BW-1:0]       i_bias,
    output logic                     o_mac_en,
    output logic [CO_W-1:0]          o_mac_co,
    output logic [CI_W-1:0]          o_mac_ci,
    input  logic                     i_psum_valid,
    input  logic signed [ACC_BW-1:0] i_psum,
    output logic                     o_ot_valid,
    output logic [CO_W-1:0]          o_ot_co,
    output logic signed [OUT_BW-1:0] o_ot_data,
    output logic                     o_done
);

    localparam int CNT_W = $clog2(CI + 1);

    // Largest positive OUT_BW-bit value, held at the extended sum width.
    localparam logic signed [ACC_BW:0] SAT_MAX =
        (ACC_BW + 1)'((64'd1 << (OUT_BW - 1)) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_BIAS
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic [CO_W-1:0]           co;
    logic [CI_W-1:0]           ci;
    logic [CNT_W-1:0]          rcv_cnt;
    logic [CNT_W-1:0]          rcv_nxt;
    logic signed [ACC_BW-1:0]  acc;
    logic [CO_W-1:0]           mac_co_q;
    logic [CI_W-1:0]           mac_ci_q;

    logic                      last_ci;
    logic                      last_co;
    logic                      psum_take;
    logic                      all_rcvd;

    logic signed [B_BW-1:0]    bias_arr [CO];
    logic signed [B_BW-1:0]    bias_sel;
    logic signed [ACC_BW:0]    acc_ext;
    logic signed [ACC_BW:0]    bias_ext;
    logic signed [ACC_BW:0]    sum_ext;
    logic signed [ACC_BW:0]    relu;
    logic signed [ACC_BW:0]    shifted;
    logic signed [OUT_BW-1:0]  sat_data;

    // Split the flat bias bus into one signed word per output channel.
    for (genvar g = 0; g < CO; g++) begin : g_bias
        assign bias_arr[g] = i_bias[g*B_BW +: B_BW];
    end

    assign last_ci   = (ci == CI_W'(CI - 1));
    assign last_co   = (co == CO_W'(CO - 1));
    assign psum_take = i_psum_valid && (state != ST_IDLE);
    assign rcv_nxt   = rcv_cnt + CNT_W'(psum_take);
    assign all_rcvd  = (rcv_nxt == CNT_W'(CI));

    // Bias add, ReLU, shift and saturate. One extra bit of width keeps the
    // accumulator-plus-bias sum from overflowing before the sign test.
    always_comb begin
        bias_sel = bias_arr[co];
        acc_ext  = {acc[ACC_BW-1], acc};
        bias_ext = {{(ACC_BW + 1 - B_BW){bias_sel[B_BW-1]}}, bias_sel};
        sum_ext  = acc_ext + (bias_ext <<< B_SHIFT);
        relu     = sum_ext[ACC_BW] ? '0 : sum_ext;
        shifted  = relu >>> O_SHIFT;
        if (shifted > SAT_MAX) begin
            sat_data = SAT_MAX[OUT_BW-1:0];
        end else begin
            sat_data = shifted[OUT_BW-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. WAIT leaves in the cycle after the last partial sum
    // of the channel is taken, so the bias step sees the complete sum.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_in_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: if (last_ci)    state_nxt = ST_WAIT;
            ST_WAIT:  if (all_rcvd)   state_nxt = ST_BIAS;
            ST_BIAS:  state_nxt = last_co ? ST_IDLE : ST_ISSUE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs. The weight selects follow the live counters while
    // issuing and otherwise show the last pair that was issued.
    always_comb begin
        o_in_ready = (state == ST_IDLE);
        o_mac_en   = (state == ST_ISSUE);
        o_mac_co   = mac_co_q;
        o_mac_ci   = mac_ci_q;
        if (state == ST_ISSUE) begin
            o_mac_co = co;
            o_mac_ci = ci;
        end
    end

    // Channel counters and the held weight-select values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            co       <= '0;
            ci       <= '0;
            mac_co_q <= '0;
            mac_ci_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        co <= '0;
                        ci <= '0;
                    end
                end
                ST_ISSUE: begin
                    mac_co_q <= co;
                    mac_ci_q <= ci;
                    ci       <= last_ci ? '0 : ci + CI_W'(1);
                end
                ST_BIAS: begin
                    if (!last_co) begin
                        co <= co + CO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Partial-sum accumulation. Sums are ignored while idle so that stray
    // results from an aborted window cannot leak into the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            rcv_cnt <= '0;
        end else if (state == ST_BIAS) begin
            acc     <= '0;
            rcv_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (i_in_valid) begin
                acc     <= '0;
                rcv_cnt <= '0;
            end
        end else if (psum_take) begin
            acc     <= acc + i_psum;
            rcv_cnt <= rcv_nxt;
        end
    end

    // Registered result outputs; valid and done are single-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_ot_valid <= 1'b0;
            o_done     <= 1'b0;
            o_ot_co    <= '0;
            o_ot_data  <= '0;
        end else begin
            o_ot_valid <= (state == ST_BIAS);
            o_done     <= (state == ST_BIAS) && last_co;
            if (state == ST_BIAS) begin
                o_ot_co   <= co;
                o_ot_data <= sat_data;
            end
        end
    end

endmodule

// File: tb/tb_conv2_ch_sched.sv
// tb_conv2_ch_sched
// Scoreboard bench for conv2_ch_sched. The stimulus side pushes expected MAC
// issues and expected results when a window is accepted; a MAC model answers
// each issue MAC_LAT cycles later, and a monitor compares each result pulse.

module tb_conv2_ch_sched;

    localparam int CO      = 3;
    localparam int CI      = 3;
    localparam int B_BW    = 16;
    localparam int ACC_BW  = 32;
    localparam int OUT_BW  = 16;
    localparam int MAC_LAT = 2;
    localparam int B_SHIFT = 0;
    localparam int O_SHIFT = 0;
    localparam int CO_W    = 2;
    localparam int CI_W    = 2;
    localparam int P       = CI + MAC_LAT + 1;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     i_in_valid;
    logic                     o_in_ready;
    logic [CO*B_BW-1:0]       i_bias;
    logic                     o_mac_en;
    logic [CO_W-1:0]          o_mac_co;
    logic [CI_W-1:0]          o_mac_ci;
    logic                     i_psum_valid = 1'b0;
    logic signed [ACC_BW-1:0] i_psum = '0;
    logic                     o_ot_valid;
    logic [CO_W-1:0]          o_ot_co;
    logic signed [OUT_BW-1:0] o_ot_data;
    logic                     o_done;

    typedef struct { int co; int data; int done; longint cyc; } res_t;
    typedef struct { int co; int ci; longint cyc; } iss_t;
    typedef struct { int val; longint cyc; } psum_t;

    res_t   exp_q[$];
    iss_t   iss_q[$];
    psum_t  pend_q[$];
    longint acc_t[$];

    int     psum_tab [CO][CI];
    int     bias_tab [CO];
    longint cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;

    conv2_ch_sched #(
        .CO(CO), .CI(CI), .B_BW(B_BW), .ACC_BW(ACC_BW), .OUT_BW(OUT_BW),
        .MAC_LAT(MAC_LAT), .B_SHIFT(B_SHIFT), .O_SHIFT(O_SHIFT),
        .CO_W(CO_W), .CI_W(CI_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_bias(i_bias),
        .o_mac_en(o_mac_en), .o_mac_co(o_mac_co), .o_mac_ci(o_mac_ci),
        .i_psum_valid(i_psum_valid), .i_psum(i_psum),
        .o_ot_valid(o_ot_valid), .o_ot_co(o_ot_co), .o_ot_data(o_ot_data),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Cycle index: inside a cycle (sampled at the falling edge) cyc names it.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint required);
        vectors++;
        if (actual != required) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, required);
        end
    endtask

    // Expected result for one output channel, straight from the arithmetic:
    // wrapped 32-bit sum of partial sums, plus bias, ReLU, shift, clamp.
    function automatic int model_out(input int c);
        int     acc;
        longint s;
        longint sat;
        acc = 0;
        sat = (longint'(1) << (OUT_BW - 1)) - 1;
        for (int k = 0; k < CI; k++) acc += psum_tab[c][k];
        s = longint'(acc) + (longint'(bias_tab[c]) << B_SHIFT);
        if (s < 0) s = 0;
        s = s >>> O_SHIFT;
        if (s > sat) s = sat;
        return int'(s);
    endfunction

    task automatic driveBias();
        for (int c = 0; c < CO; c++) i_bias[c*B_BW +: B_BW] = bias_tab[c][B_BW-1:0];
    endtask

    task automatic loadDirected(input int p0, input int p1, input int p2,
                                input int b0, input int b1, input int b2);
        for (int c = 0; c < CO; c++) begin
            psum_tab[c][0] = p0;
            psum_tab[c][1] = p1;
            psum_tab[c][2] = p2;
        end
        bias_tab[0] = b0;
        bias_tab[1] = b1;
        bias_tab[2] = b2;
        driveBias();
    endtask

    task automatic loadRandom();
        logic [15:0] b;
        for (int c = 0; c < CO; c++) begin
            for (int k = 0; k < CI; k++) begin
                case ($urandom_range(0, 3))
                    0: psum_tab[c][k] = int'($urandom_range(0, 2000)) - 1000;
                    1: psum_tab[c][k] = int'($urandom_range(32'h8000, 32'h20000));
                    2: psum_tab[c][k] = int'($urandom);
                    default: psum_tab[c][k] = -int'($urandom_range(0, 40000));
                endcase
            end
            b = 16'($urandom);
            bias_tab[c] = $signed(b);
        end
        driveBias();
    endtask

    task automatic pushExpected(input longint t);
        for (int c = 0; c < CO; c++) begin
            for (int k = 0; k < CI; k++) iss_q.push_back('{c, k, t + 1 + c*P + k});
            exp_q.push_back('{c, model_out(c), (c == CO-1) ? 1 : 0, t + c*P + CI + MAC_LAT + 2});
        end
        acc_t.push_back(t);
    endtask

    // Holds i_in_valid high until nwin windows have been accepted.
    task automatic applyStimulus(input int nwin);
        int accepted;
        int waited;
        accepted = 0;
        waited = 0;
        @(negedge clk);
        i_in_valid = 1'b1;
        while (accepted < nwin) begin
            if (o_in_ready) begin
                pushExpected(cyc);
                accepted++;
                waited = 0;
                if (accepted == nwin) break;
            end
            @(negedge clk);
            waited++;
            if (waited > 100) begin
                checkOutput("accept_timeout", 0, 1);
                break;
            end
        end
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            iss_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_ready"}, o_in_ready, 1);
        checkOutput({tag, "_mac_en"},   o_mac_en,   0);
        checkOutput({tag, "_mac_co"},   o_mac_co,   0);
        checkOutput({tag, "_mac_ci"},   o_mac_ci,   0);
        checkOutput({tag, "_ot_valid"}, o_ot_valid, 0);
        checkOutput({tag, "_ot_co"},    o_ot_co,    0);
        checkOutput({tag, "_ot_data"},  o_ot_data,  0);
        checkOutput({tag, "_done"},     o_done,     0);
    endtask

    // MAC model: answers each issue MAC_LAT cycles later, checking the issue
    // against the expected (co, ci, cycle). In-flight answers survive reset.
    always @(negedge clk) begin
        i_psum_valid = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].cyc == cyc) begin
            i_psum_valid = 1'b1;
            i_psum = pend_q[0].val;
            void'(pend_q.pop_front());
        end
        if (reset_n && o_mac_en) begin
            iss_t e;
            int   v;
            v = (int'(o_mac_co) < CO && int'(o_mac_ci) < CI) ? psum_tab[o_mac_co][o_mac_ci] : 0;
            pend_q.push_back('{v, cyc + MAC_LAT});
            if (iss_q.size() == 0) begin
                checkOutput("unexpected_mac_en", 1, 0);
            end else begin
                e = iss_q.pop_front();
                checkOutput("mac_co",    o_mac_co, e.co);
                checkOutput("mac_ci",    o_mac_ci, e.ci);
                checkOutput("mac_cycle", cyc,      e.cyc);
            end
        end
    end

    // Result monitor.
    always @(negedge clk) begin
        if (reset_n) begin
            if (o_done && !o_ot_valid) checkOutput("done_without_valid", 1, 0);
            if (o_ot_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_ot_valid", 1, 0);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    checkOutput("ot_co",    o_ot_co,   r.co);
                    checkOutput("ot_data",  o_ot_data, r.data);
                    checkOutput("ot_done",  o_done,    r.done);
                    checkOutput("ot_cycle", cyc,       r.cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        longint t;
        reset_n    = 1'b0;
        i_in_valid = 1'b0;
        i_bias     = '0;
        repeat (3) @(negedge clk);
        checkReset("por");
        reset_n = 1'b1;

        $display("[TB] basic window");
        loadDirected(10, 20, 30, 5, -7, 0);
        applyStimulus(1);
        waitDrain();

        $display("[TB] relu window");
        loadDirected(-100, -100, -100, 50, 50, 50);
        applyStimulus(1);
        waitDrain();

        $display("[TB] saturation window");
        loadDirected(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 0, 0, 0);
        applyStimulus(1);
        waitDrain();

        $display("[TB] back-to-back windows");
        acc_t.delete();
        loadDirected(10, 20, 30, 5, -7, 0);
        applyStimulus(2);
        checkOutput("accept_gap", acc_t[1] - acc_t[0], CO*P + 1);
        waitDrain();

        $display("[TB] abort during channel 1");
        acc_t.delete();
        loadDirected(10, 20, 30, 5, -7, 0);
        applyStimulus(1);
        t = acc_t[0];
        while (cyc < t + P + 2) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        iss_q.delete();
        @(negedge clk);
        checkReset("abort");
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checkOutput("quiet_ot_valid", o_ot_valid, 0);
            checkOutput("quiet_done",     o_done,     0);
        end
        checkOutput("late_psums_drained", pend_q.size(), 0);
        loadDirected(10, 20, 30, 5, -7, 0);
        applyStimulus(1);
        waitDrain();

        $display("[TB] random windows");
        for (int w = 0; w < 12; w++) begin
            loadRandom();
            applyStimulus(int'($urandom_range(1, 2)));
            waitDrain();
        end

        checkOutput("results_left", exp_q.size(), 0);
        checkOutput("issues_left",  iss_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
